// File: rtl/mem_io_pkg.sv
// Purpose: shared encodings for the memory-stage IO controller: writeback and
//          memory-select codes, RV32 opcodes, IO register offsets and default
//          MMIO addresses, plus the opcode decode helper.
// Ports:   none (package).
package mem_io_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_IDX_W = 3;   // enough to index up to 8 counters

  // Writeback source select
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Memory target select
  localparam logic [1:0] MSEL_DMEM = 2'd0;
  localparam logic [1:0] MSEL_BIOS = 2'd1;
  localparam logic [1:0] MSEL_IO   = 2'd2;

  // Address region tags in addr[31:28]
  localparam logic [3:0] BIOS_REGION = 4'h4;
  localparam logic [3:0] IO_REGION   = 4'h8;

  // UART register offsets from IO_BASE
  localparam logic [XLEN-1:0] IO_OFF_STATUS = 32'h0000_0000;
  localparam logic [XLEN-1:0] IO_OFF_RX     = 32'h0000_0004;
  localparam logic [XLEN-1:0] IO_OFF_TX     = 32'h0000_0008;

  // Default MMIO map
  localparam logic [XLEN-1:0] DEF_IO_BASE      = 32'h8000_0000;
  localparam logic [XLEN-1:0] DEF_CNT_RST_ADDR = 32'h8000_0018;
  localparam logic [XLEN-1:0] DEF_CNT_BASE     = 32'h8000_0020;

  // RV32 major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       is_load;
    logic       is_store;
  } dec_t;

  // Opcode -> writeback controls; unknown opcodes behave like STORE/BRANCH (no write)
  function automatic dec_t decode_op(input logic [6:0] opc);
    dec_t d;
    d.reg_we   = 1'b0;
    d.wb_sel   = WB_ALU;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    case (opc)
      OPC_R, OPC_IMM, OPC_AUIPC, OPC_LUI: d.reg_we = 1'b1;
      OPC_LOAD: begin
        d.reg_we  = 1'b1;
        d.wb_sel  = WB_MEM;
        d.is_load = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d.reg_we = 1'b1;
        d.wb_sel = WB_PC4;
      end
      OPC_STORE: d.is_store = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/io_counter_bank.sv
// Purpose: bank of NUM_CNT free-running perf counters. Counter 0 counts every
//          cycle, counter k>0 counts i_evt[k]. Synchronous clear beats increment.
// Ports:   clk, rst_n       clock / async active-low reset
//          i_clr            clear all counters next cycle
//          i_evt            per-cycle event pulses (bit 0 ignored)
//          i_rd_idx         counter index to read
//          o_rd_data_c      selected counter zero-extended to 32 (0 if out of range)
module io_counter_bank
  import mem_io_pkg::*;
#(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic [NUM_CNT-1:0]   i_evt,
  input  logic [CNT_IDX_W-1:0] i_rd_idx,
  output logic [XLEN-1:0]      o_rd_data_c
);

  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] w_inc;

  // Counter 0 is the cycle counter, so its event is tied high
  always_comb begin
    w_inc    = i_evt;
    w_inc[0] = 1'b1;
  end

  // Counters keep running through pipeline stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_CNT); k++) r_cnt[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < int'(NUM_CNT); k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_CNT); k++) begin
        if (w_inc[k]) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  // Read mux
  always_comb begin
    o_rd_data_c = '0;
    for (int k = 0; k < int'(NUM_CNT); k++) begin
      if (i_rd_idx == CNT_IDX_W'(k)) o_rd_data_c = XLEN'(r_cnt[k]);
    end
  end

endmodule

// File: rtl/mem_stage_io_ctrl.sv
// Purpose: memory-stage control decode plus MMIO controller (UART TX holding
//          register, RX pop, perf counters). IO load data is registered so it
//          lines up with the synchronous DMEM read.
// Ports:   clk, rst_n                   clock / async active-low reset
//          inst_memory, mem_addr,       MEM-stage instruction, address,
//          store_data, mem_valid, stall store data, valid, pipeline stall
//          cnt_evt                      perf counter event pulses
//          uart_tx_*/uart_rx_*          UART byte handshakes
//          reg_we, wb_sel, load_type,   writeback/load controls (combinational)
//          byte_addr, mem_sel
//          io_rdata                     registered IO load data
module mem_stage_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int unsigned    NUM_CNT      = 4,
  parameter int unsigned    CNT_W        = 32,
  parameter logic [31:0]    IO_BASE      = DEF_IO_BASE,
  parameter logic [31:0]    CNT_RST_ADDR = DEF_CNT_RST_ADDR,
  parameter logic [31:0]    CNT_BASE     = DEF_CNT_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst_memory,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        store_data,
  input  logic               mem_valid,
  input  logic               stall,
  input  logic [NUM_CNT-1:0] cnt_evt,
  input  logic               uart_tx_ready,
  input  logic               uart_rx_valid,
  input  logic [7:0]         uart_rx_data,
  output logic               uart_tx_valid,
  output logic [7:0]         uart_tx_data,
  output logic               uart_rx_ready,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic [2:0]         load_type,
  output logic [1:0]         byte_addr,
  output logic [1:0]         mem_sel,
  output logic [31:0]        io_rdata
);

  dec_t                 w_dec;
  logic                 w_act;
  logic                 w_io_ld;
  logic                 w_io_st;
  logic                 w_hit_status;
  logic                 w_hit_rx;
  logic                 w_hit_tx;
  logic                 w_hit_cnt_rst;
  logic                 w_hit_cnt;
  logic [XLEN-1:0]      w_cnt_off;
  logic [CNT_IDX_W-1:0] w_cnt_idx;
  logic [XLEN-1:0]      w_cnt_rdata;
  logic [XLEN-1:0]      w_rd_mux;
  logic                 w_tx_push;
  logic                 w_tx_drop;
  logic                 w_unused_bits;

  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic                 r_overrun;
  logic [XLEN-1:0]      r_io_rdata;

  // Fields of the instruction/store word this stage has no use for
  assign w_unused_bits = ^{store_data[31:8], inst_memory[31:15], inst_memory[11:7]};

  // Writeback / load decode
  always_comb begin
    w_dec     = decode_op(inst_memory[6:0]);
    reg_we    = w_dec.reg_we & mem_valid;
    wb_sel    = w_dec.wb_sel;
    load_type = w_dec.is_load ? inst_memory[14:12] : 3'd0;
    byte_addr = w_dec.is_load ? mem_addr[1:0] : 2'd0;
  end

  // Region select from the top address nibble
  always_comb begin
    mem_sel = MSEL_DMEM;
    case (mem_addr[31:28])
      BIOS_REGION: mem_sel = MSEL_BIOS;
      IO_REGION:   mem_sel = MSEL_IO;
      default:     mem_sel = MSEL_DMEM;
    endcase
  end

  // IO access qualification and address match
  always_comb begin
    w_act         = mem_valid & ~stall;
    w_io_ld       = w_act & w_dec.is_load  & (mem_sel == MSEL_IO);
    w_io_st       = w_act & w_dec.is_store & (mem_sel == MSEL_IO);
    w_hit_status  = (mem_addr == IO_BASE + IO_OFF_STATUS);
    w_hit_rx      = (mem_addr == IO_BASE + IO_OFF_RX);
    w_hit_tx      = (mem_addr == IO_BASE + IO_OFF_TX);
    w_hit_cnt_rst = (mem_addr == CNT_RST_ADDR);
    // Addresses below CNT_BASE wrap to a huge offset and miss the range check
    w_cnt_off     = mem_addr - CNT_BASE;
    w_hit_cnt     = (w_cnt_off[31:2] < 30'(NUM_CNT)) && (w_cnt_off[1:0] == 2'b00);
    w_cnt_idx     = w_cnt_off[CNT_IDX_W+1:2];
    w_tx_push     = w_io_st & w_hit_tx & ~r_tx_valid;
    w_tx_drop     = w_io_st & w_hit_tx & r_tx_valid;
    uart_rx_ready = w_io_ld & w_hit_rx & uart_rx_valid;
  end

  // IO read data mux; unmapped IO addresses read as zero
  always_comb begin
    w_rd_mux = '0;
    if (w_hit_status)   w_rd_mux = {29'd0, r_overrun, uart_rx_valid, ~r_tx_valid};
    else if (w_hit_rx)  w_rd_mux = {24'd0, uart_rx_data};
    else if (w_hit_cnt) w_rd_mux = w_cnt_rdata;
  end

  io_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_io_st & w_hit_cnt_rst),
    .i_evt       (cnt_evt),
    .i_rd_idx    (w_cnt_idx),
    .o_rd_data_c (w_cnt_rdata)
  );

  // TX holding register: a byte arriving while one is pending is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else if (w_tx_push) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= store_data[7:0];
    end else if (r_tx_valid && uart_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Sticky overrun, cleared by a status read (the read returns the old value)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_tx_drop) begin
      r_overrun <= 1'b1;
    end else if (w_io_ld && w_hit_status) begin
      r_overrun <= 1'b0;
    end
  end

  // IO load data, held between IO loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_rdata <= '0;
    end else if (w_io_ld) begin
      r_io_rdata <= w_rd_mux;
    end
  end

  assign uart_tx_valid = r_tx_valid;
  assign uart_tx_data  = r_tx_data;
  assign io_rdata      = r_io_rdata;

endmodule

// File: tb/tb_mem_stage_io_ctrl.sv
// Purpose: directed self-checking bench for mem_stage_io_ctrl (8-bit counters).
module tb_mem_stage_io_ctrl;

  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [31:0] A_STAT = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CRST = 32'h8000_0018;
  localparam logic [31:0] A_CNT  = 32'h8000_0020;
  localparam logic [31:0] I_LW   = 32'h0000_2003;
  localparam logic [31:0] I_SW   = 32'h0000_2023;

  logic               clk;
  logic               rst_n;
  logic [31:0]        inst_memory;
  logic [31:0]        mem_addr;
  logic [31:0]        store_data;
  logic               mem_valid;
  logic               stall;
  logic [NUM_CNT-1:0] cnt_evt;
  logic               uart_tx_ready;
  logic               uart_rx_valid;
  logic [7:0]         uart_rx_data;
  logic               uart_tx_valid;
  logic [7:0]         uart_tx_data;
  logic               uart_rx_ready;
  logic               reg_we;
  logic [1:0]         wb_sel;
  logic [2:0]         load_type;
  logic [1:0]         byte_addr;
  logic [1:0]         mem_sel;
  logic [31:0]        io_rdata;

  int vecs = 0;
  int errs = 0;

  mem_stage_io_ctrl #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_memory   (inst_memory),
    .mem_addr      (mem_addr),
    .store_data    (store_data),
    .mem_valid     (mem_valid),
    .stall         (stall),
    .cnt_evt       (cnt_evt),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_rx_ready (uart_rx_ready),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .load_type     (load_type),
    .byte_addr     (byte_addr),
    .mem_sel       (mem_sel),
    .io_rdata      (io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_memory = 32'h0;
    mem_addr    = 32'h0;
    store_data  = 32'h0;
    mem_valid   = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic drive_ld(input logic [31:0] a);
    inst_memory = I_LW;
    mem_addr    = a;
    mem_valid   = 1'b1;
  endtask

  task automatic drive_sw(input logic [31:0] a, input logic [31:0] d);
    inst_memory = I_SW;
    mem_addr    = a;
    store_data  = d;
    mem_valid   = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    cnt_evt = '0; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
    rst_n = 1'b0;
    repeat (3) tick();
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL rst_tx_valid got %b exp 0", uart_tx_valid); end
    vecs++; if (uart_tx_data !== 8'h00) begin errs++; $display("FAIL rst_tx_data got %h exp 00", uart_tx_data); end
    vecs++; if (io_rdata !== 32'h0) begin errs++; $display("FAIL rst_io_rdata got %h exp 0", io_rdata); end
    vecs++; if (uart_rx_ready !== 1'b0) begin errs++; $display("FAIL rst_rx_ready got %b exp 0", uart_rx_ready); end
    vecs++; if (reg_we !== 1'b0) begin errs++; $display("FAIL rst_reg_we got %b exp 0", reg_we); end
    rst_n = 1'b1;
    drive_ld(A_CNT + 32'd4); tick();
    vecs++; if (io_rdata !== 32'h0) begin errs++; $display("FAIL rst_ctr1 got %h exp 0", io_rdata); end
    drive_ld(A_STAT); tick();
    vecs++; if (io_rdata !== 32'h1) begin errs++; $display("FAIL rst_status got %h exp 1", io_rdata); end
    idle();
  endtask

  task automatic test_decode();
    logic [6:0] opc_t [11] = '{7'h33, 7'h13, 7'h17, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h7F};
    logic       we_t  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] wb_t  [11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    logic       is_ld;
    logic       exp_we;
    logic [2:0] exp_lt;
    logic [1:0] exp_ba;
    mem_addr = 32'h4000_0003;
    for (int i = 0; i < 11; i++) begin
      for (int v = 0; v < 2; v++) begin
        mem_valid   = (v == 1);
        inst_memory = {17'd0, 3'b101, 5'd3, opc_t[i]};
        #1;
        is_ld  = (i == 4);
        exp_we = we_t[i] & (v == 1);
        exp_lt = is_ld ? 3'b101 : 3'b000;
        exp_ba = is_ld ? 2'd3 : 2'd0;
        vecs++; if (reg_we !== exp_we) begin errs++; $display("FAIL dec_we op=%h v=%0d got %b exp %b", opc_t[i], v, reg_we, exp_we); end
        vecs++; if (wb_sel !== wb_t[i]) begin errs++; $display("FAIL dec_wb op=%h v=%0d got %0d exp %0d", opc_t[i], v, wb_sel, wb_t[i]); end
        vecs++; if (load_type !== exp_lt) begin errs++; $display("FAIL dec_lt op=%h v=%0d got %0d exp %0d", opc_t[i], v, load_type, exp_lt); end
        vecs++; if (byte_addr !== exp_ba) begin errs++; $display("FAIL dec_ba op=%h v=%0d got %0d exp %0d", opc_t[i], v, byte_addr, exp_ba); end
        vecs++; if (mem_sel !== 2'd1) begin errs++; $display("FAIL dec_msel op=%h v=%0d got %0d exp 1", opc_t[i], v, mem_sel); end
      end
    end
    mem_valid = 1'b0; mem_addr = 32'h8000_0000; #1;
    vecs++; if (mem_sel !== 2'd2) begin errs++; $display("FAIL msel_io got %0d exp 2", mem_sel); end
    mem_addr = 32'h1234_5678; #1;
    vecs++; if (mem_sel !== 2'd0) begin errs++; $display("FAIL msel_dmem got %0d exp 0", mem_sel); end
    idle();
    tick();
  endtask

  task automatic test_tx();
    uart_tx_ready = 1'b0;
    drive_sw(A_TX, 32'hABCD_EF41); tick(); idle();
    for (int i = 0; i < 4; i++) begin
      uart_tx_ready = (i == 3);
      vecs++; if (uart_tx_valid !== 1'b1) begin errs++; $display("FAIL tx_valid c%0d got %b exp 1", i, uart_tx_valid); end
      vecs++; if (uart_tx_data !== 8'h41) begin errs++; $display("FAIL tx_data c%0d got %h exp 41", i, uart_tx_data); end
      tick();
    end
    uart_tx_ready = 1'b0;
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL tx_clear got %b exp 0", uart_tx_valid); end
    drive_sw(A_TX, 32'h55); stall = 1'b1; tick(); idle();
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL tx_stall got %b exp 0", uart_tx_valid); end
    drive_sw(32'h8000_0010, 32'h66); tick(); idle();
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL tx_unmapped got %b exp 0", uart_tx_valid); end
  endtask

  task automatic test_overrun();
    uart_tx_ready = 1'b0;
    drive_sw(A_TX, 32'h11); tick();
    drive_sw(A_TX, 32'h22); tick(); idle();
    vecs++; if (uart_tx_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got %b exp 1", uart_tx_valid); end
    vecs++; if (uart_tx_data !== 8'h11) begin errs++; $display("FAIL ovr_data got %h exp 11", uart_tx_data); end
    drive_ld(A_STAT); tick();
    vecs++; if (io_rdata !== 32'h4) begin errs++; $display("FAIL ovr_stat1 got %h exp 4", io_rdata); end
    drive_ld(A_STAT); tick(); idle();
    vecs++; if (io_rdata !== 32'h0) begin errs++; $display("FAIL ovr_stat2 got %h exp 0", io_rdata); end
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL ovr_drain got %b exp 0", uart_tx_valid); end
    // store landing on the handshake cycle is dropped too
    drive_sw(A_TX, 32'h33); tick();
    drive_sw(A_TX, 32'h44); uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0; idle();
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL hs_valid got %b exp 0", uart_tx_valid); end
    vecs++; if (uart_tx_data !== 8'h33) begin errs++; $display("FAIL hs_data got %h exp 33", uart_tx_data); end
    drive_ld(A_STAT); tick();
    vecs++; if (io_rdata !== 32'h5) begin errs++; $display("FAIL hs_stat1 got %h exp 5", io_rdata); end
    drive_ld(A_STAT); tick(); idle();
    vecs++; if (io_rdata !== 32'h1) begin errs++; $display("FAIL hs_stat2 got %h exp 1", io_rdata); end
  endtask

  task automatic test_rx();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    drive_ld(A_RX); #1;
    vecs++; if (uart_rx_ready !== 1'b1) begin errs++; $display("FAIL rx_pulse got %b exp 1", uart_rx_ready); end
    tick(); idle(); #1;
    vecs++; if (uart_rx_ready !== 1'b0) begin errs++; $display("FAIL rx_pulse_end got %b exp 0", uart_rx_ready); end
    vecs++; if (io_rdata !== 32'h5A) begin errs++; $display("FAIL rx_data got %h exp 5a", io_rdata); end
    uart_rx_data = 8'h77;
    drive_ld(A_RX); stall = 1'b1; #1;
    vecs++; if (uart_rx_ready !== 1'b0) begin errs++; $display("FAIL rx_stall_pulse got %b exp 0", uart_rx_ready); end
    tick(); idle();
    vecs++; if (io_rdata !== 32'h5A) begin errs++; $display("FAIL rx_stall_hold got %h exp 5a", io_rdata); end
    drive_ld(A_STAT); tick();
    vecs++; if (io_rdata !== 32'h3) begin errs++; $display("FAIL rx_status got %h exp 3", io_rdata); end
    drive_ld(32'h8000_000C); tick(); idle();
    vecs++; if (io_rdata !== 32'h0) begin errs++; $display("FAIL io_unmapped got %h exp 0", io_rdata); end
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_counters();
    drive_sw(A_CRST, 32'h0); tick(); idle();
    for (int i = 0; i < 260; i++) begin
      cnt_evt = '0;
      if (i < 14 && (i % 2) == 0) cnt_evt[1] = 1'b1;
      if (i >= 20 && i < 23) cnt_evt[3] = 1'b1;
      stall = (i >= 100 && i < 150);
      tick();
    end
    cnt_evt = '0; stall = 1'b0;
    drive_ld(A_CNT); tick();
    vecs++; if (io_rdata !== 32'd4) begin errs++; $display("FAIL ctr0_wrap got %0d exp 4", io_rdata); end
    drive_ld(A_CNT + 32'd4); tick();
    vecs++; if (io_rdata !== 32'd7) begin errs++; $display("FAIL ctr1 got %0d exp 7", io_rdata); end
    drive_ld(A_CNT + 32'd12); tick();
    vecs++; if (io_rdata !== 32'd3) begin errs++; $display("FAIL ctr3 got %0d exp 3", io_rdata); end
    drive_ld(A_CNT + 32'd16); tick();
    vecs++; if (io_rdata !== 32'd0) begin errs++; $display("FAIL ctr_oob got %0d exp 0", io_rdata); end
    // clear takes priority over same-cycle events
    drive_sw(A_CRST, 32'h0); cnt_evt = 4'b1111; tick(); cnt_evt = '0;
    drive_ld(A_CNT); tick();
    vecs++; if (io_rdata !== 32'd0) begin errs++; $display("FAIL clr_ctr0 got %0d exp 0", io_rdata); end
    drive_ld(A_CNT + 32'd4); tick();
    vecs++; if (io_rdata !== 32'd0) begin errs++; $display("FAIL clr_ctr1 got %0d exp 0", io_rdata); end
    drive_ld(A_CNT + 32'd12); tick(); idle();
    vecs++; if (io_rdata !== 32'd0) begin errs++; $display("FAIL clr_ctr3 got %0d exp 0", io_rdata); end
  endtask

  task automatic test_async_reset();
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b1; uart_rx_data = 8'h3C;
    drive_sw(A_TX, 32'h99); tick();
    drive_ld(A_RX); tick(); idle(); uart_rx_valid = 1'b0;
    vecs++; if (uart_tx_valid !== 1'b1) begin errs++; $display("FAIL ar_pre_valid got %b exp 1", uart_tx_valid); end
    vecs++; if (io_rdata !== 32'h3C) begin errs++; $display("FAIL ar_pre_rdata got %h exp 3c", io_rdata); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL ar_tx_valid got %b exp 0", uart_tx_valid); end
    vecs++; if (uart_tx_data !== 8'h00) begin errs++; $display("FAIL ar_tx_data got %h exp 00", uart_tx_data); end
    vecs++; if (io_rdata !== 32'h0) begin errs++; $display("FAIL ar_io_rdata got %h exp 0", io_rdata); end
    vecs++; if (uart_rx_ready !== 1'b0) begin errs++; $display("FAIL ar_rx_ready got %b exp 0", uart_rx_ready); end
    tick();
    rst_n = 1'b1;
    drive_ld(A_CNT); tick();
    vecs++; if (io_rdata !== 32'd0) begin errs++; $display("FAIL ar_ctr0 got %0d exp 0", io_rdata); end
    idle(); tick();
    vecs++; if (uart_tx_valid !== 1'b0) begin errs++; $display("FAIL ar_post_valid got %b exp 0", uart_tx_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_tx();
    test_overrun();
    test_rx();
    test_counters();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
